complex_div_seq: RTL

- Sequential complex divider; the inverse operation of the existing complex add/multiply datapath.
- Computes Q = (a_re + j·a_im) / (c_re + j·c_im) with an iterative restoring divider.
- Takes operands through a valid/ready handshake and returns the result through a second valid/ready handshake.
- Sits downstream of the complex multiply stage, for normalisation and channel-equalisation paths.

---
 rtl/complex_div_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/complex_div_seq.sv
// rtl/complex_div_seq.sv - sequential complex divider, Q = a / c, via two parallel restoring dividers
// Optional round-half-away-from-zero in the sign stage when COMPLEX_DIV_ROUND_EN is defined.
module complex_div_seq #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] c_re,
    input  logic signed [WIDTH-1:0] c_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   q_re,
    output logic signed [WIDTH:0]   q_im,
    output logic                    div_by_zero
);
    localparam int PW = 2 * WIDTH;
    localparam int NW = PW + 1;
    localparam int OW = WIDTH + 1;
    localparam int CW = $clog2(PW) + 1;
    localparam logic [CW-1:0] LAST = CW'(PW - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic signed [WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
    logic [NW-1:0]           den_q, den_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [PW-1:0]           qre_q, qre_d, qim_q, qim_d;
    logic [PW-1:0]           rre_q, rre_d, rim_q, rim_d;
    logic                    sre_q, sre_d, sim_q, sim_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [OW-1:0]    q_re_q, q_re_d, q_im_q, q_im_d;
    logic                    dbz_q, dbz_d;

    logic signed [NW-1:0]    are_x, aim_x, cre_x, cim_x;
    logic signed [NW-1:0]    num_re, num_im, den_s;
    logic [NW-1:0]           re_sh, im_sh;
    logic                    re_ge, im_ge;
    logic [OW-1:0]           mag_re, mag_im;

    always_comb begin
        are_x  = NW'(a_re_q);
        aim_x  = NW'(a_im_q);
        cre_x  = NW'(c_re_q);
        cim_x  = NW'(c_im_q);
        num_re = are_x * cre_x + aim_x * cim_x;
        num_im = aim_x * cre_x - are_x * cim_x;
        den_s  = cre_x * cre_x + cim_x * cim_x;
        re_sh  = {rre_q, qre_q[PW-1]};
        im_sh  = {rim_q, qim_q[PW-1]};
        re_ge  = (re_sh >= den_q);
        im_ge  = (im_sh >= den_q);
`ifdef COMPLEX_DIV_ROUND_EN
        mag_re = qre_q[OW-1:0] + OW'({rre_q, 1'b0} >= den_q);
        mag_im = qim_q[OW-1:0] + OW'({rim_q, 1'b0} >= den_q);
`else
        mag_re = qre_q[OW-1:0];
        mag_im = qim_q[OW-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        c_re_d  = c_re_q;
        c_im_d  = c_im_q;
        den_d   = den_q;
        qre_d   = qre_q;
        qim_d   = qim_q;
        rre_d   = rre_q;
        rim_d   = rim_q;
        sre_d   = sre_q;
        sim_d   = sim_q;
        cnt_d   = cnt_q;
        q_re_d  = q_re_q;
        q_im_d  = q_im_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_re_d  = a_re;
                    a_im_d  = a_im;
                    c_re_d  = c_re;
                    c_im_d  = c_im;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (den_s == '0) begin
                    q_re_d  = '0;
                    q_im_d  = '0;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    den_d   = den_s;
                    qre_d   = num_re[NW-1] ? PW'(-num_re) : PW'(num_re);
                    qim_d   = num_im[NW-1] ? PW'(-num_im) : PW'(num_im);
                    sre_d   = num_re[NW-1];
                    sim_d   = num_im[NW-1];
                    rre_d   = '0;
                    rim_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rre_d = re_ge ? PW'(re_sh - den_q) : re_sh[PW-1:0];
                rim_d = im_ge ? PW'(im_sh - den_q) : im_sh[PW-1:0];
                qre_d = {qre_q[PW-2:0], re_ge};
                qim_d = {qim_q[PW-2:0], im_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                q_re_d  = sre_q ? -mag_re : mag_re;
                q_im_d  = sim_q ? -mag_im : mag_im;
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_re_q  <= '0;
            a_im_q  <= '0;
            c_re_q  <= '0;
            c_im_q  <= '0;
            den_q   <= '0;
            qre_q   <= '0;
            qim_q   <= '0;
            rre_q   <= '0;
            rim_q   <= '0;
            sre_q   <= 1'b0;
            sim_q   <= 1'b0;
            cnt_q   <= '0;
            q_re_q  <= '0;
            q_im_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            c_re_q  <= c_re_d;
            c_im_q  <= c_im_d;
            den_q   <= den_d;
            qre_q   <= qre_d;
            qim_q   <= qim_d;
            rre_q   <= rre_d;
            rim_q   <= rim_d;
            sre_q   <= sre_d;
            sim_q   <= sim_d;
            cnt_q   <= cnt_d;
            q_re_q  <= q_re_d;
            q_im_q  <= q_im_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign q_re        = q_re_q;
    assign q_im        = q_im_q;
    assign div_by_zero = dbz_q;

endmodule
